// File: rtl/gol_sequencer.sv
// Game of Life generation sequencer: walks the row register file once per start,
// rewriting each row in place from a 3-row sliding window plus a saved row 0.

module gol_cell (
  input  logic [2:0] top,
  input  logic [2:0] mid,
  input  logic [2:0] bot,
  output logic       nxt
);
  // bit [1] is the cell itself, [0]/[2] are its column neighbours
  logic [3:0] n;
  assign n = 4'(top[0]) + 4'(top[1]) + 4'(top[2]) + 4'(mid[0]) + 4'(mid[2])
           + 4'(bot[0]) + 4'(bot[1]) + 4'(bot[2]);
  assign nxt = (n == 4'd3) | (mid[1] & (n == 4'd2));
endmodule

module gol_sequencer #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input  logic               ph2,
  input  logic               reset_n,
  input  logic               start,
  input  logic               run,
  input  logic               clear,
  input  logic [WIDTH-1:0]   rd,
  output logic [REGBITS-1:0] ra,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  output logic               regwrite,
  output logic               rf_reset,
  output logic               busy,
  output logic               done,
  output logic [GENBITS-1:0] gen_count
);
  localparam logic [REGBITS-1:0] LAST = REGBITS'(2**REGBITS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_TOP, LOAD_MID, STEP, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   top, mid, row0, bot, life;
  logic [REGBITS-1:0] r;

  // the last row wraps onto the original row 0, which has already been overwritten
  assign bot = (r == LAST) ? row0 : rd;

  for (genvar c = 0; c < WIDTH; c++) begin : g_cell
    localparam int CL = (c == 0) ? WIDTH - 1 : c - 1;
    localparam int CR = (c == WIDTH - 1) ? 0 : c + 1;
    gol_cell u_cell (
      .top ({top[CR], top[c], top[CL]}),
      .mid ({mid[CR], mid[c], mid[CL]}),
      .bot ({bot[CR], bot[c], bot[CL]}),
      .nxt (life[c])
    );
  end

  always_comb begin
    ra       = '0;
    wa       = '0;
    wd       = '0;
    regwrite = 1'b0;
    rf_reset = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      CLEAR:    rf_reset = 1'b1;
      LOAD_TOP: ra = LAST;
      STEP: begin
        ra       = r + REGBITS'(1);
        wa       = r;
        wd       = life;
        regwrite = 1'b1;
      end
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge ph2 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      top       <= '0;
      mid       <= '0;
      row0      <= '0;
      r         <= '0;
      gen_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear)      state <= CLEAR;
          else if (start) state <= LOAD_TOP;
        end
        CLEAR: begin
          gen_count <= '0;
          state     <= IDLE;
        end
        LOAD_TOP: begin
          top   <= rd;
          state <= LOAD_MID;
        end
        LOAD_MID: begin
          mid   <= rd;
          row0  <= rd;
          r     <= '0;
          state <= STEP;
        end
        STEP: begin
          top <= mid;
          mid <= bot;
          r   <= r + REGBITS'(1);
          if (r == LAST) state <= DONE;
        end
        DONE: begin
          gen_count <= gen_count + GENBITS'(1);
          state     <= (run && !clear) ? LOAD_TOP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gol_sequencer.sv
// Self-checking bench for gol_sequencer: a row register file model plus a
// cell-by-cell toroidal Life reference computed on the whole board.

module tb_gol_sequencer;
  typedef logic [7:0][7:0] board_t;

  logic        ph2 = 1'b0;
  logic        reset_n, start, run, clear;
  logic [7:0]  rd, wd;
  logic [2:0]  ra, wa;
  logic        regwrite, rf_reset, busy, done;
  logic [15:0] gen_count;

  board_t mem, pl_data;
  logic   pl_en;
  int     tests = 0;
  int     fails = 0;

  localparam board_t SEED = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'b00010000, 8'b00110000, 8'b00011000};

  gol_sequencer #(.WIDTH(8), .REGBITS(3), .GENBITS(16)) dut (
    .ph2(ph2), .reset_n(reset_n), .start(start), .run(run), .clear(clear),
    .rd(rd), .ra(ra), .wa(wa), .wd(wd), .regwrite(regwrite), .rf_reset(rf_reset),
    .busy(busy), .done(done), .gen_count(gen_count)
  );

  always #5 ph2 = ~ph2;

  assign rd = mem[ra];
  always @(posedge ph2) begin
    if (rf_reset)      mem <= SEED;
    else if (regwrite) mem[wa] <= wd;
    else if (pl_en)    mem <= pl_data;
  end

  function automatic board_t life_gen(input board_t b);
    board_t o;
    int n;
    for (int rr = 0; rr < 8; rr++)
      for (int cc = 0; cc < 8; cc++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += int'(b[(rr + dr + 8) % 8][(cc + dc + 8) % 8]);
        o[rr][cc] = (n == 3) || (b[rr][cc] && n == 2);
      end
    return o;
  endfunction

  function automatic board_t rand_board();
    board_t b;
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    return b;
  endfunction

  task automatic tick();
    @(posedge ph2);
    #1;
  endtask

  task automatic preload(input board_t b);
    pl_data = b;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic run_one(output int bc, output int da, output int nw, output bit ord);
    bc = 0; da = 0; nw = 0; ord = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && busy; k++) begin
      bc++;
      if (done) da = bc;
      if (regwrite) begin
        if (wa !== 3'(nw)) ord = 1'b0;
        nw++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int wr, bz;
    reset_n = 1'b0; start = 1'b0; run = 1'b0; clear = 1'b0; pl_en = 1'b0;
    #1;
    tests++;
    if ({ra, wa, wd, regwrite, rf_reset, busy, done, gen_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ra=%h wa=%h wd=%h we=%b rfr=%b busy=%b done=%b gc=%h, want all 0",
               ra, wa, wd, regwrite, rf_reset, busy, done, gen_count);
    end
    tick(); tick();
    reset_n = 1'b1;
    wr = 0; bz = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      wr += int'(regwrite);
      bz += int'(busy);
    end
    tests++;
    if (wr !== 0 || bz !== 0) begin
      fails++;
      $display("FAIL idle_quiet: got writes=%0d busy_cycles=%0d, want 0/0", wr, bz);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    tests++;
    if (rf_reset !== 1'b1) begin
      fails++;
      $display("FAIL clear_rf_reset: got %b want 1", rf_reset);
    end
    clear = 1'b0;
    tick();
  endtask

  task automatic test_clear_step();
    int bc, da, nw;
    bit ord;
    board_t e;
    do_clear();
    tests++;
    if (gen_count !== 16'd0 || mem !== SEED) begin
      fails++;
      $display("FAIL clear_state: got gc=%0d board=%h, want 0 board=%h", gen_count, mem, SEED);
    end
    run_one(bc, da, nw, ord);
    e = '0;
    e[0] = 8'b00111000; e[1] = 8'b00100000; e[2] = 8'b00110000;
    tests++;
    if (mem !== e || mem !== life_gen(SEED)) begin
      fails++;
      $display("FAIL seed_step_board: got %h want %h", mem, e);
    end
    tests++;
    if (bc !== 11 || da !== 11 || nw !== 8 || !ord || gen_count !== 16'd1) begin
      fails++;
      $display("FAIL seed_step_timing: got busy=%0d done_at=%0d writes=%0d order=%b gc=%0d, want 11/11/8/1/1",
               bc, da, nw, ord, gen_count);
    end
  endtask

  task automatic test_blinker_wrap();
    int bc, da, nw;
    bit ord;
    board_t b, e1;
    b = '0; b[0] = 8'b11000001;
    e1 = '0; e1[7] = 8'b10000000; e1[0] = 8'b10000000; e1[1] = 8'b10000000;
    preload(b);
    run_one(bc, da, nw, ord);
    tests++;
    if (mem !== e1) begin
      fails++;
      $display("FAIL blinker_gen1: got %h want %h", mem, e1);
    end
    run_one(bc, da, nw, ord);
    tests++;
    if (mem !== b) begin
      fails++;
      $display("FAIL blinker_gen2: got %h want %h", mem, b);
    end
  endtask

  task automatic test_random();
    int bc, da, nw;
    bit ord;
    board_t b;
    for (int it = 0; it < 6; it++) begin
      b = rand_board();
      preload(b);
      run_one(bc, da, nw, ord);
      tests++;
      if (mem !== life_gen(b) || bc !== 11 || nw !== 8 || !ord) begin
        fails++;
        $display("FAIL random_gen%0d: got board=%h busy=%0d writes=%0d order=%b, want board=%h 11/8/1",
                 it, mem, bc, nw, ord, life_gen(b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int gens, nw, cyc, last_done;
    int wexp;
    bit gap_ok, ord;
    board_t b, e;
    do_clear();
    b = rand_board();
    preload(b);
    e = b;
    for (int i = 0; i < 5; i++) e = life_gen(e);
    gens = 0; nw = 0; wexp = 0; last_done = -1; gap_ok = 1'b1; ord = 1'b1; cyc = 0;
    run = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        if (last_done >= 0 && cyc - last_done != 11) gap_ok = 1'b0;
        last_done = cyc;
        gens++;
        if (gens == 5) run = 1'b0;
      end
      if (regwrite) begin
        if (wa !== 3'(wexp)) ord = 1'b0;
        wexp = (wexp + 1) % 8;
        nw++;
      end
      if (!busy) break;
      tick();
      cyc++;
    end
    run = 1'b0;
    tests++;
    if (gens !== 5 || !gap_ok || nw !== 40 || !ord || busy !== 1'b0) begin
      fails++;
      $display("FAIL run_timing: got gens=%0d gap_ok=%b writes=%0d order=%b busy=%b, want 5/1/40/1/0",
               gens, gap_ok, nw, ord, busy);
    end
    tests++;
    if (gen_count !== 16'd5 || mem !== e) begin
      fails++;
      $display("FAIL run_result: got gc=%0d board=%h, want 5 board=%h", gen_count, mem, e);
    end
  endtask

  task automatic test_busy_inputs();
    int bc, bz;
    logic [15:0] g0;
    board_t b;
    b = rand_board();
    preload(b);
    g0 = gen_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      bc++;
      start = (bc == 5);
      clear = (bc == 5);
      tick();
    end
    start = 1'b0; clear = 1'b0;
    tests++;
    if (bc !== 11 || mem !== life_gen(b) || gen_count !== g0 + 16'd1) begin
      fails++;
      $display("FAIL busy_ignore: got busy=%0d gc=%0d board=%h, want 11 gc=%0d board=%h",
               bc, gen_count, mem, g0 + 16'd1, life_gen(b));
    end
    bz = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bz += int'(busy);
    end
    tests++;
    if (bz !== 0) begin
      fails++;
      $display("FAIL no_queue: got busy_cycles=%0d want 0", bz);
    end
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    tests++;
    if (rf_reset !== 1'b1 || regwrite !== 1'b0) begin
      fails++;
      $display("FAIL clear_wins: got rf_reset=%b regwrite=%b want 1/0", rf_reset, regwrite);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || gen_count !== 16'd0 || mem !== SEED) begin
      fails++;
      $display("FAIL clear_wins_result: got busy=%b gc=%0d board=%h want 0/0 board=%h",
               busy, gen_count, mem, SEED);
    end
  endtask

  task automatic test_reset_mid_step();
    int bc, da, nw;
    bit ord;
    board_t b, e;
    run_one(bc, da, nw, ord);
    b = rand_board();
    preload(b);
    e = life_gen(b);
    for (int i = 4; i < 8; i++) e[i] = b[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if (regwrite !== 1'b1 || wa !== 3'd4) begin
      fails++;
      $display("FAIL pre_abort_row: got regwrite=%b wa=%0d want 1/4", regwrite, wa);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (regwrite !== 1'b0 || busy !== 1'b0 || gen_count !== 16'd0) begin
      fails++;
      $display("FAIL abort_outputs: got regwrite=%b busy=%b gc=%0d want 0/0/0", regwrite, busy, gen_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tests++;
    if (mem !== e || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_board: got %h busy=%b want %h busy=0", mem, busy, e);
    end
  endtask

  initial begin
    test_reset();
    test_clear_step();
    test_blinker_wrap();
    test_random();
    test_back_to_back();
    test_busy_inputs();
    test_reset_mid_step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gol_sequencer.md
# gol_sequencer

Generation sequencer for the Game of Life row register file (`current_state`). On each start it walks the 8-row board once and overwrites every row in place with its next-generation value, using a 3-row sliding window plus a saved copy of row 0. It owns the register file's read address, write port and reset. It sits between the top-level run/step controls and the row storage.

## Interface
- `WIDTH`, 8, cells per row (bits per register-file word)
- `REGBITS`, 3, row-address width; board has 2**REGBITS rows
- `GENBITS`, 16, width of the generation counter
- `ph2`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request one generation; sampled in IDLE only
- `run`  in  1  when 1 at DONE, start the next generation immediately
- `clear`  in  1  reload the seed pattern; sampled in IDLE only
- `rd`  in  WIDTH  register-file read data (combinational from `ra`)
- `ra`  out  REGBITS  register-file read address
- `wa`  out  REGBITS  register-file write address
- `wd`  out  WIDTH  register-file write data
- `regwrite`  out  1  register-file write enable
- `rf_reset`  out  1  register-file reset (loads the seed)
- `busy`  out  1  high from leaving IDLE until returning to IDLE
- `done`  out  1  one-cycle pulse when a generation completes
- `gen_count`  out  GENBITS  completed generations since the last clear

## Operation
- States: IDLE, CLEAR, LOAD_TOP, LOAD_MID, STEP, DONE.
- Internal registers: `top`, `mid`, `row0`, a row index `r`, and `gen_count`.
- IDLE: if `clear` is high, go to CLEAR. Otherwise, if `start` is high, go to LOAD_TOP. `clear` wins when both are high; that `start` is dropped.
- CLEAR: `rf_reset`=1 for one cycle. `gen_count`<=0. Go to IDLE.
- LOAD_TOP: `ra`=2**REGBITS-1. `top`<=`rd`.
- LOAD_MID: `ra`=0. `mid`<=`rd` and `row0`<=`rd`. `r`<=0.
- STEP, row r, one cycle per row:
  - `ra`=r+1 (mod 2**REGBITS).
  - bot = `row0` if r is the last row, else `rd`.
  - `wd`=life(`top`,`mid`,bot). `wa`=r. `regwrite`=1.
  - At the edge: `top`<=`mid`, `mid`<=bot, `r`<=r+1.
  - After the last row, go to DONE.
- In-place update is safe: each row's original value is held in `top`/`mid` before that row is overwritten, and `row0` supplies the original row 0 for the last row.
- DONE: `done`=1, `gen_count`<=`gen_count`+1, with modulo 2**GENBITS wrap. Then:
  - if `run`=1 and `clear`=0, go to LOAD_TOP;
  - otherwise go to IDLE.
- Life rule, per cell c of `mid`:
  - n = count of the 8 neighbours across `top`/`mid`/bot.
  - Columns wrap toroidally: column −1 is column WIDTH-1, and vice versa.
  - next = (n==3) | (mid[c] & n==2).
  - n is a 4-bit unsigned value with no saturation.
- Rows wrap toroidally: the neighbour above row 0 is the last row, and the neighbour below the last row is row 0.
- `start`/`clear` outside IDLE are ignored, not queued. `run` is sampled only in DONE.
- `ra`, `wa`, `wd`, `regwrite`, `rf_reset`, `busy`, `done` are combinational from state, `r` and `rd`. In non-STEP states: `regwrite`=0, `wa`=0, `wd`=0. In IDLE/CLEAR/DONE: `ra`=0.

## Timing
- Reset (`reset_n`=0) takes effect immediately, asynchronously:
  - state=IDLE;
  - `top`, `mid`, `row0`, `r`, `gen_count` = 0;
  - hence `regwrite`=0, `rf_reset`=0, `busy`=0, `done`=0, `ra`=`wa`=0, `wd`=0.
- Reset mid-generation aborts with no further writes. Rows already written hold generation g+1 and the rest hold g. The board is not repaired; recovery is `clear`.
- Latency from the `start` edge in IDLE: `busy` the next cycle. Then LOAD_TOP (1) + LOAD_MID (1) + STEP (2**REGBITS) + DONE (1) = 11 cycles busy for the default size.
- `done` is high in the 11th busy cycle. `gen_count` updates at the end of that cycle.
- With `run`=1, back-to-back generations run every 11 cycles, with no IDLE cycle between them.
- Register-file reads must be combinational within the cycle. Writes are committed during the same `ph2` phase in which `regwrite` is asserted.

## Test plan
- Reset/idle: hold `reset_n`=0, then release.
  - -> all outputs 0 and `busy`=0.
  - -> no `regwrite` for 20 cycles with `start`=0.
- Clear then step: pulse `clear`, then `start`, on the seed board (rows 0..2 = 00011000, 00110000, 00010000).
  - -> rows become 00111000, 00100000, 00110000; rows 3..7 = 0.
  - -> `gen_count`=1, `done` pulse at busy cycle 11.
- Blinker with toroidal wrap: preload row 0 = 11000001, all other rows 0. Run two generations.
  - -> generation 1: rows 7, 0, 1 = 10000000.
  - -> generation 2: row 0 = 11000001, others 0.
- Continuous run: `run`=1 for 5 generations.
  - -> `done` pulses exactly 11 cycles apart.
  - -> exactly 8 writes per generation to `wa`=0..7 in order.
  - -> `gen_count`=5.
- Busy-time inputs: assert `start` and `clear` during STEP.
  - -> both are ignored and the generation completes normally.
  - -> `start` and `clear` asserted together in IDLE -> CLEAR only, with no generation.
- Reset mid-STEP: assert `reset_n`=0 at r=4.
  - -> `regwrite` drops immediately and the FSM returns to IDLE.
  - -> rows 0..3 hold the new generation and rows 4..7 the old.
  - -> `gen_count`=0.
